// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan controller: segment patterns,
// letter glyphs, the hex decode table and the scan FSM state encoding.
// All segment patterns are active-low and ordered {CA,CB,CC,CD,CE,CF,CG}.
package ssd_pkg;

  localparam logic [6:0] SSD_OFF      = 7'b1111111;
  localparam logic [6:0] SSD_LETTER_L = 7'b1110001;
  localparam logic [6:0] SSD_LETTER_A = 7'b0001000;
  localparam logic [6:0] SSD_LETTER_R = 7'b1111010;

  // Index 15 is the leftmost entry, index 0 the rightmost.
  localparam logic [15:0][6:0] SSD_HEX_TABLE = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // D
    7'b0110001,  // C
    7'b1100000,  // B
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } ssd_state_e;

  function automatic logic [6:0] ssd_hex_to_seg(input logic [3:0] hex);
    return SSD_HEX_TABLE[hex];
  endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational hex digit to active-low seven-segment pattern decoder.
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  // Table lookup of the segment pattern for one hex digit
  always_comb begin
    o_seg = ssd_hex_to_seg(i_hex);
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment display scanner. Each digit owns a fixed slot:
// a short blanked (dead) interval against ghosting, then the lit interval.
// All data inputs are captured once per frame so a frame is never torn.
// Optional feature macro: SSD_BRIGHTNESS_EN adds a 4-bit brightness input
// that PWM-gates the anode during the lit interval.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SLOT_CYCLES = 262144,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                      Clk,
  input  logic                      reset_n,
  input  logic [4*NUM_DIGITS-1:0]   hex_in,
  input  logic [NUM_DIGITS-1:0]     raw_sel,
  input  logic [7*NUM_DIGITS-1:0]   raw_seg,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     digit_en,
`ifdef SSD_BRIGHTNESS_EN
  input  logic [3:0]                brightness,
`endif
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic                      frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SLOT_CYCLES);

  // A slot must open with at least one blanked cycle (it also marks the
  // frame start) and leave at least two lit cycles.
  generate
    if ((NUM_DIGITS < 1) || (NUM_DIGITS > 8) || (DEAD_CYCLES < 1) ||
        (SLOT_CYCLES <= DEAD_CYCLES + 1)) begin : g_bad_params
      $error("ssd_scan_ctrl: illegal NUM_DIGITS/SLOT_CYCLES/DEAD_CYCLES");
    end
  endgenerate

  ssd_state_e                      r_state;
  ssd_state_e                      w_state_nxt;
  logic [CNT_W-1:0]                r_cnt;
  logic [CNT_W-1:0]                w_cnt_nxt;
  logic [IDX_W-1:0]                r_idx;
  logic [IDX_W-1:0]                w_idx_nxt;
  logic                            w_slot_end;
  logic                            w_frame_start;
  logic                            w_pwm_on;

  logic [NUM_DIGITS-1:0][3:0]      r_hex_snap;
  logic [NUM_DIGITS-1:0][6:0]      r_raw_seg_snap;
  logic [NUM_DIGITS-1:0]           r_raw_sel_snap;
  logic [NUM_DIGITS-1:0]           r_dp_snap;
  logic [NUM_DIGITS-1:0]           r_en_snap;

  logic [6:0]                      w_dec_seg;
  logic [NUM_DIGITS-1:0]           w_an_nxt;
  logic [6:0]                      w_seg_nxt;
  logic                            w_dp_nxt;

  logic [NUM_DIGITS-1:0]           r_an;
  logic [6:0]                      r_seg;
  logic                            r_dp;
  logic                            r_frame_tick;

  assign w_slot_end    = (r_cnt == CNT_W'(SLOT_CYCLES - 1));
  assign w_frame_start = (r_state == ST_BLANK) && (r_cnt == '0) && (r_idx == '0);

  // Slot counter and digit index: index advances on the SHOW->BLANK edge
  always_comb begin
    w_cnt_nxt = w_slot_end ? '0 : (r_cnt + CNT_W'(1));
    w_idx_nxt = r_idx;
    if (w_slot_end) begin
      w_idx_nxt = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : (r_idx + IDX_W'(1));
    end else begin
      w_idx_nxt = r_idx;
    end
  end

  // Next-state logic of the BLANK/SHOW scan FSM
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BLANK: begin
        if (w_cnt_nxt == CNT_W'(DEAD_CYCLES)) w_state_nxt = ST_SHOW;
        else                                 w_state_nxt = ST_BLANK;
      end
      ST_SHOW: begin
        if (w_slot_end) w_state_nxt = ST_BLANK;
        else            w_state_nxt = ST_SHOW;
      end
      default: w_state_nxt = ST_BLANK;
    endcase
  end

  // FSM state, slot counter and digit index registers
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Per-frame capture of all display data inputs
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      r_hex_snap     <= '0;
      r_raw_seg_snap <= '0;
      r_raw_sel_snap <= '0;
      r_dp_snap      <= '0;
      r_en_snap      <= '0;
    end else if (w_frame_start) begin
      r_hex_snap     <= hex_in;
      r_raw_seg_snap <= raw_seg;
      r_raw_sel_snap <= raw_sel;
      r_dp_snap      <= dp_in;
      r_en_snap      <= digit_en;
    end else begin
      r_hex_snap     <= r_hex_snap;
      r_raw_seg_snap <= r_raw_seg_snap;
      r_raw_sel_snap <= r_raw_sel_snap;
      r_dp_snap      <= r_dp_snap;
      r_en_snap      <= r_en_snap;
    end
  end

`ifdef SSD_BRIGHTNESS_EN
  logic [3:0] r_pwm;
  logic [3:0] r_bright_snap;

  // PWM phase runs through SHOW and restarts at phase 0 in every slot
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      r_pwm         <= 4'd0;
      r_bright_snap <= 4'd0;
    end else begin
      r_pwm         <= (r_state == ST_SHOW) ? (r_pwm + 4'd1) : 4'd0;
      r_bright_snap <= w_frame_start ? brightness : r_bright_snap;
    end
  end

  assign w_pwm_on = (r_pwm <= r_bright_snap);
`else
  assign w_pwm_on = 1'b1;
`endif

  ssd_hex_decode u_hex_decode (
    .i_hex (r_hex_snap[r_idx]),
    .o_seg (w_dec_seg)
  );

  // Drive pattern for the current slot; everything dark while blanked
  always_comb begin
    w_an_nxt  = '1;
    w_seg_nxt = SSD_OFF;
    w_dp_nxt  = 1'b1;
    if (r_state == ST_SHOW) begin
      w_an_nxt[r_idx] = ~(r_en_snap[r_idx] & w_pwm_on);
      w_seg_nxt       = r_raw_sel_snap[r_idx] ? r_raw_seg_snap[r_idx] : w_dec_seg;
      w_dp_nxt        = ~r_dp_snap[r_idx];
    end else begin
      w_an_nxt  = '1;
      w_seg_nxt = SSD_OFF;
      w_dp_nxt  = 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      r_an         <= '1;
      r_seg        <= SSD_OFF;
      r_dp         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_frame_tick <= w_frame_start;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl (4 digits, 8-cycle slots, 2 dead cycles).
// The stimulus process pushes the expected lit windows of each frame; a
// monitor detects every lit window on the anodes and checks it.
module tb_ssd_scan_ctrl;

  localparam int ND   = 4;
  localparam int SLOT = 8;
  localparam int DEAD = 2;
  localparam int LIT  = SLOT - DEAD;

  logic          Clk = 1'b0;
  logic          reset_n;
  logic [15:0]   hex_in;
  logic [3:0]    raw_sel;
  logic [27:0]   raw_seg;
  logic [3:0]    dp_in;
  logic [3:0]    digit_en;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_tick;
`ifdef SSD_BRIGHTNESS_EN
  logic [3:0]    brightness = 4'hF;
`endif

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } win_t;

  win_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b1;

  ssd_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SLOT_CYCLES (SLOT),
    .DEAD_CYCLES (DEAD)
  ) dut (
    .Clk        (Clk),
    .reset_n    (reset_n),
    .hex_in     (hex_in),
    .raw_sel    (raw_sel),
    .raw_seg    (raw_seg),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
`ifdef SSD_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d);
    win_t w;
    w.an = a; w.seg = s; w.dp = d;
    exp_q.push_back(w);
  endtask

  task automatic set_cfg(input logic [15:0] h, input logic [3:0] en,
                         input logic [3:0] rs, input logic [27:0] rg, input logic [3:0] dpi);
    hex_in = h; digit_en = en; raw_sel = rs; raw_seg = rg; dp_in = dpi;
  endtask

  task automatic wait_tick(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 4 * SLOT * ND && !seen; i++) begin
      @(negedge Clk);
      if (frame_tick) seen = 1'b1;
    end
    if (!seen) chk({name, "_tick_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  task automatic push_cfg_a();
    push(4'b1110, 7'b0000001, 1'b1);
    push(4'b1101, 7'b1001111, 1'b1);
    push(4'b1011, 7'b0010010, 1'b1);
    push(4'b0111, 7'b0000110, 1'b1);
  endtask

  // Monitor: frame_tick period and every lit anode window against the queue
  int   since_tick = 0;
  bit   have_tick  = 1'b0;
  bit   prev_tick  = 1'b0;
  bit   in_win     = 1'b0;
  int   win_len    = 0;
  bit   win_stable = 1'b1;
  win_t cur;

  always @(negedge Clk) begin
    if (!reset_n) begin
      have_tick = 1'b0; prev_tick = 1'b0; in_win = 1'b0; since_tick = 0;
    end else begin
      since_tick++;
      if (frame_tick) begin
        if (prev_tick) chk("tick_width", 32'd2, 32'd1);
        if (have_tick) chk("tick_period", since_tick, ND * SLOT);
        have_tick  = 1'b1;
        since_tick = 0;
      end
      prev_tick = frame_tick;

      if (an != 4'b1111) begin
        if (!in_win || an != cur.an) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_window_an", {28'd0, an}, 32'hF);
            cur.an = an; cur.seg = seg; cur.dp = dp;
          end else begin
            cur = exp_q.pop_front();
            chk("win_an",  {28'd0, an},  {28'd0, cur.an});
            chk("win_seg", {25'd0, seg}, {25'd0, cur.seg});
            chk("win_dp",  {31'd0, dp},  {31'd0, cur.dp});
          end
          in_win = 1'b1; win_len = 1; win_stable = 1'b1;
          cur.an = an;
        end else begin
          win_len++;
          if (seg != cur.seg || dp != cur.dp) win_stable = 1'b0;
        end
      end else if (in_win) begin
        in_win = 1'b0;
        if (mon_en) begin
          chk("win_len", win_len, LIT);
          chk("win_stable", {31'd0, win_stable}, 32'd1);
        end
      end
    end
  end

  // Stimulus: each configuration is applied mid-frame and shows next frame
  initial begin
    reset_n = 1'b0;
    set_cfg(16'h3210, 4'hF, 4'h0, 28'h0, 4'h0);
    wait_cycles(3);
    chk("rst_an",   {28'd0, an},  32'hF);
    chk("rst_seg",  {25'd0, seg}, 32'h7F);
    chk("rst_dp",   {31'd0, dp},  32'd1);
    chk("rst_tick", {31'd0, frame_tick}, 32'd0);

    push_cfg_a();
    reset_n = 1'b1;
    wait_tick("first");

    // digits 1 and 3 disabled
    wait_cycles(10);
    set_cfg(16'h3210, 4'b0101, 4'h0, 28'h0, 4'h0);
    push(4'b1110, 7'b0000001, 1'b1);
    push(4'b1011, 7'b0010010, 1'b1);
    wait_tick("cfg_b");

    // digit 0 raw "L" with decimal point, other raw slices ignored
    wait_cycles(10);
    set_cfg(16'h3210, 4'hF, 4'b0001,
            {7'b0101010, 7'b0101010, 7'b0101010, 7'b1110001}, 4'b0001);
    push(4'b1110, 7'b1110001, 1'b0);
    push(4'b1101, 7'b1001111, 1'b1);
    push(4'b1011, 7'b0010010, 1'b1);
    push(4'b0111, 7'b0000110, 1'b1);
    wait_tick("cfg_c");

    // all F, changed mid-frame: current frame must keep the old values
    wait_cycles(10);
    set_cfg(16'hFFFF, 4'hF, 4'h0, 28'h0, 4'h0);
    push(4'b1110, 7'b0111000, 1'b1);
    push(4'b1101, 7'b0111000, 1'b1);
    push(4'b1011, 7'b0111000, 1'b1);
    push(4'b0111, 7'b0111000, 1'b1);
    wait_tick("cfg_d");

    // letters A,7,E,B with decimal point on digit 3
    wait_cycles(10);
    set_cfg(16'hBE7A, 4'hF, 4'h0, 28'h0, 4'b1000);
    push(4'b1110, 7'b0001000, 1'b1);
    push(4'b1101, 7'b0001111, 1'b1);
    push(4'b1011, 7'b0110000, 1'b1);
    push(4'b0111, 7'b1100000, 1'b0);
    wait_tick("cfg_e");

    // reset in the middle of digit 2's lit interval
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 2 * SLOT * ND && !seen; i++) begin
        @(negedge Clk);
        if (an == 4'b1011) seen = 1'b1;
      end
      if (!seen) chk("digit2_timeout", 32'd0, 32'd1);
    end
    wait_cycles(2);
    mon_en = 1'b0;
    exp_q.delete();
    reset_n = 1'b0;
    set_cfg(16'h3210, 4'hF, 4'h0, 28'h0, 4'h0);
    @(negedge Clk);
    chk("midrst_an",   {28'd0, an},  32'hF);
    chk("midrst_seg",  {25'd0, seg}, 32'h7F);
    chk("midrst_dp",   {31'd0, dp},  32'd1);
    chk("midrst_tick", {31'd0, frame_tick}, 32'd0);
    wait_cycles(2);
    push_cfg_a();
    mon_en = 1'b1;
    reset_n = 1'b1;
    wait_tick("restart");
    wait_tick("restart_next");
    @(negedge Clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
